wb_trace_buffer: RTL and testbench
==================================

Name: wb_trace_buffer

Overview:
- Hardware consumer for the CPU's debug_WriteBackData stream; the on-chip counterpart of the bench monitor.
- Captures write-back values into a circular buffer and drains them to a host/debug port over a valid/ready handshake.
- Sits beside Single_CPU at top level:
  - wb_data is tied to debug_WriteBackData.
  - wb_valid is tied to the CPU's register-write strobe.

Parameters:
- DATA_W, 32, width of captured write-back word.
- DEPTH, 16, number of buffer entries; power of two, at least 2.
- ADDR_W, 4, log2(DEPTH).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- wb_data  input  DATA_W  write-back value from the CPU.
- wb_valid  input  1  wb_data is a real write-back this cycle.
- arm  input  1  single-cycle pulse that starts capture.
- stop  input  1  single-cycle pulse that ends capture.
- clear  input  1  single-cycle pulse that flushes the buffer and flags.
- wrap_mode  input  1  1 = overwrite oldest entry when full; 0 = freeze when full.
- rd_ready  input  1  host accepts rd_data this cycle.
- rd_data  output  DATA_W  oldest entry (first-word fall-through).
- rd_valid  output  1  rd_data holds a valid entry.
- count  output  ADDR_W+1  number of stored entries, 0..DEPTH.
- full  output  1  count == DEPTH.
- overflow  output  1  sticky; at least one entry was overwritten or dropped.
- state  output  2  IDLE=0, RUN=1, FROZEN=2.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, pointers=0, count=0, overflow=0.
  - rd_valid=0, full=0, rd_data=0.
  - Memory contents are don't-care.
- FSM:
  - IDLE: arm -> RUN.
  - RUN: stop -> IDLE.
  - RUN with push while full and wrap_mode=0 -> FROZEN. The push is dropped and overflow is set.
  - FROZEN: arm -> RUN (only captures if space is available). stop -> IDLE.
  - clear from any state -> IDLE. Pointers, count and overflow go to 0. clear has priority over all other inputs.
- Push = (state==RUN) & wb_valid.
  - A push in the same cycle as arm is ignored; capture begins the cycle after arm.
  - A push in the same cycle as stop is still accepted.
- Pop = rd_valid & rd_ready. rd_valid = (count != 0). rd_data = mem[rd_ptr], combinational from registered pointer/memory.
- Latency: a word pushed on edge N appears on rd_data with rd_valid=1 after edge N (visible in cycle N+1) if the buffer was empty.
- Pointers are ADDR_W bits and wrap modulo DEPTH.
- count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on push and pop together.
- Boundary cases:
  - Empty, push and pop together: pop has no effect (rd_valid=0). count becomes 1.
  - Full, push and pop together: accepted in both modes. count stays DEPTH; no overflow.
  - Full, wrap_mode=1, push without pop: write at wr_ptr (== rd_ptr), advance both pointers, count stays DEPTH, overflow=1, state stays RUN.
  - Full, wrap_mode=0, push without pop: data dropped, overflow=1, go to FROZEN.
- Reading is allowed in every state, including IDLE and FROZEN. Draining in FROZEN does not restart capture.
- overflow is cleared only by clear or reset.
- arm does not flush; existing entries are kept.

Test Plan:
- Reset and basic flow:
  - Hold rst=0 for 20 ns, release, then pulse arm.
  - Push 0x00000005, 0x0000000A, 0x0000000F with rd_ready=0.
  - Expect count=3, rd_valid=1, rd_data=0x00000005.
  - Set rd_ready=1: drain order 5, A, F, then rd_valid=0 and count=0.
- Freeze on full:
  - wrap_mode=0, arm, push 17 words 0x100..0x110.
  - Expect full=1, count=16, overflow=1, state=FROZEN.
  - Drain yields 0x100..0x10F; 0x110 is absent.
- Wrap mode:
  - wrap_mode=1, push 20 words 0x200..0x213.
  - Expect count=16, overflow=1, state=RUN.
  - Drain yields 0x204..0x213.
- Simultaneous push and pop at boundaries:
  - Full + push + pop: count stays 16, overflow=0.
  - Empty + push + pop: count=1, and the pushed word is read next.
- Control priority:
  - wb_valid=1 on the same cycle as arm: not captured.
  - Push on the same cycle as stop: captured, then state=IDLE.
  - clear with arm asserted together: state=IDLE, count=0.
- Reset mid-capture:
  - Assert rst=0 asynchronously between edges with count=7.
  - Outputs go to reset values immediately, without waiting for a clock edge.
  - After release, state=IDLE and rd_valid=0.

Source files
------------

// File: rtl/wb_trace_buffer.sv
// Write-back trace buffer: captures CPU register write-back values into a
// circular buffer and drains them oldest-first over a valid/ready port.
module wb_trace_buffer #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              wb_valid,
   input  logic              arm,
   input  logic              stop,
   input  logic              clear,
   input  logic              wrap_mode,
   input  logic              rd_ready,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic [ADDR_W:0]   count,
   output logic              full,
   output logic              overflow,
   output logic [1:0]        state
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      FROZEN = 2'd2
   } state_t;

   localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

   state_t            st;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W:0]   cnt;
   logic              ovf;

   logic push;
   logic pop;
   logic is_full;
   logic do_wr;
   logic adv_rd;
   logic drop;
   logic ovw;
   logic cnt_inc;
   logic cnt_dec;

   assign is_full = (cnt == FULL_CNT);
   assign push    = (st == RUN) & wb_valid;
   assign pop     = (cnt != '0) & rd_ready;

   // A full buffer still accepts a push when a pop frees a slot or when
   // wrapping; a wrapping push overwrites the oldest entry.
   assign do_wr   = push & (~is_full | pop | wrap_mode);
   assign drop    = push & is_full & ~pop & ~wrap_mode;
   assign ovw     = push & is_full & ~pop & wrap_mode;
   assign adv_rd  = pop | ovw;
   assign cnt_inc = do_wr & ~pop & ~is_full;
   assign cnt_dec = pop & ~do_wr;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st     <= IDLE;
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         ovf    <= 1'b0;
      end else if (clear) begin
         st     <= IDLE;
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         ovf    <= 1'b0;
      end else begin
         if (do_wr)
            wr_ptr <= wr_ptr + 1'b1;
         if (adv_rd)
            rd_ptr <= rd_ptr + 1'b1;
         if (cnt_inc)
            cnt <= cnt + 1'b1;
         else if (cnt_dec)
            cnt <= cnt - 1'b1;
         if (drop | ovw)
            ovf <= 1'b1;
         unique case (st)
            IDLE: begin
               if (arm)
                  st <= RUN;
            end
            RUN: begin
               if (stop)
                  st <= IDLE;
               else if (drop)
                  st <= FROZEN;
            end
            FROZEN: begin
               if (stop)
                  st <= IDLE;
               else if (arm)
                  st <= RUN;
            end
            default: st <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr && !clear)
         mem[wr_ptr] <= wb_data;
   end

   assign rd_valid = (cnt != '0);
   assign rd_data  = rd_valid ? mem[rd_ptr] : '0;
   assign count    = cnt;
   assign full     = is_full;
   assign overflow = ovf;
   assign state    = st;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed bench for wb_trace_buffer with a queue scoreboard of
// expected drain order.
module tb_wb_trace_buffer;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] wb_data;
   logic        wb_valid;
   logic        arm;
   logic        stop;
   logic        clear;
   logic        wrap_mode;
   logic        rd_ready;
   logic [31:0] rd_data;
   logic        rd_valid;
   logic [4:0]  count;
   logic        full;
   logic        overflow;
   logic [1:0]  state;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q [$];

   wb_trace_buffer #(.DATA_W(32), .DEPTH(16), .ADDR_W(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .wb_data  (wb_data),
      .wb_valid (wb_valid),
      .arm      (arm),
      .stop     (stop),
      .clear    (clear),
      .wrap_mode(wrap_mode),
      .rd_ready (rd_ready),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .count    (count),
      .full     (full),
      .overflow (overflow),
      .state    (state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: inputs set at negedge, outputs observed at next negedge.
   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   // mode 0: word dropped, 1: word kept, 2: kept and oldest overwritten
   task automatic push_word(input logic [31:0] d, input int mode);
      wb_valid = 1'b1;
      wb_data  = d;
      cyc();
      wb_valid = 1'b0;
      if (mode == 2 && exp_q.size() != 0)
         void'(exp_q.pop_front());
      if (mode != 0)
         exp_q.push_back(d);
   endtask

   task automatic drain(input int n);
      logic [31:0] e;
      rd_ready = 1'b1;
      for (int i = 0; i < n; i++) begin
         e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
         chk("drain_valid", 32'(rd_valid), 32'd1);
         chk("drain_data", rd_data, e);
         cyc();
      end
      rd_ready = 1'b0;
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      cyc();
      clear = 1'b0;
      exp_q.delete();
   endtask

   task automatic pulse_arm();
      arm = 1'b1;
      cyc();
      arm = 1'b0;
   endtask

   initial begin
      rst = 1'b0;
      wb_data = '0;
      wb_valid = 1'b0;
      arm = 1'b0;
      stop = 1'b0;
      clear = 1'b0;
      wrap_mode = 1'b0;
      rd_ready = 1'b0;

      #12;
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_valid", 32'(rd_valid), 32'd0);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      chk("rst_data", rd_data, 32'd0);
      #8;
      rst = 1'b1;

      // basic flow
      pulse_arm();
      chk("arm_state", 32'(state), 32'd1);
      push_word(32'h5, 1);
      chk("first_latency_valid", 32'(rd_valid), 32'd1);
      push_word(32'hA, 1);
      push_word(32'hF, 1);
      chk("basic_count", 32'(count), 32'd3);
      chk("basic_head", rd_data, 32'h5);
      drain(3);
      chk("basic_empty_valid", 32'(rd_valid), 32'd0);
      chk("basic_empty_count", 32'(count), 32'd0);

      // freeze on full
      wrap_mode = 1'b0;
      pulse_arm();
      for (int i = 0; i < 17; i++)
         push_word(32'h100 + 32'(i), (i < 16) ? 1 : 0);
      chk("frz_full", 32'(full), 32'd1);
      chk("frz_count", 32'(count), 32'd16);
      chk("frz_ovf", 32'(overflow), 32'd1);
      chk("frz_state", 32'(state), 32'd2);
      drain(16);
      chk("frz_drained_count", 32'(count), 32'd0);
      chk("frz_stays_frozen", 32'(state), 32'd2);
      chk("frz_ovf_sticky", 32'(overflow), 32'd1);

      // wrap mode
      pulse_clear();
      chk("clr_ovf", 32'(overflow), 32'd0);
      chk("clr_state", 32'(state), 32'd0);
      wrap_mode = 1'b1;
      pulse_arm();
      for (int i = 0; i < 20; i++)
         push_word(32'h200 + 32'(i), (i < 16) ? 1 : 2);
      chk("wrap_count", 32'(count), 32'd16);
      chk("wrap_ovf", 32'(overflow), 32'd1);
      chk("wrap_state", 32'(state), 32'd1);
      drain(16);

      // full + push + pop, freeze mode
      pulse_clear();
      wrap_mode = 1'b0;
      pulse_arm();
      for (int i = 0; i < 16; i++)
         push_word(32'h300 + 32'(i), 1);
      chk("fpp_pre_full", 32'(full), 32'd1);
      rd_ready = 1'b1;
      chk("fpp_head", rd_data, exp_q.pop_front());
      push_word(32'h310, 1);
      rd_ready = 1'b0;
      chk("fpp_count", 32'(count), 32'd16);
      chk("fpp_ovf", 32'(overflow), 32'd0);
      chk("fpp_state", 32'(state), 32'd1);
      drain(16);

      // empty + push + pop
      chk("epp_pre_count", 32'(count), 32'd0);
      rd_ready = 1'b1;
      push_word(32'h400, 1);
      rd_ready = 1'b0;
      chk("epp_count", 32'(count), 32'd1);
      drain(1);
      chk("epp_after", 32'(count), 32'd0);

      // push with stop is captured
      stop = 1'b1;
      push_word(32'h500, 1);
      stop = 1'b0;
      chk("stop_state", 32'(state), 32'd0);
      chk("stop_count", 32'(count), 32'd1);
      chk("stop_data", rd_data, 32'h500);

      // push with arm is ignored
      arm = 1'b1;
      push_word(32'h600, 0);
      arm = 1'b0;
      chk("arm_push_state", 32'(state), 32'd1);
      chk("arm_push_count", 32'(count), 32'd1);

      // clear beats arm
      arm = 1'b1;
      pulse_clear();
      arm = 1'b0;
      chk("clr_arm_state", 32'(state), 32'd0);
      chk("clr_arm_count", 32'(count), 32'd0);

      // asynchronous reset mid-capture
      pulse_arm();
      for (int i = 0; i < 7; i++)
         push_word(32'h700 + 32'(i), 1);
      chk("mid_count", 32'(count), 32'd7);
      #2;
      rst = 1'b0;
      #1;
      chk("async_count", 32'(count), 32'd0);
      chk("async_valid", 32'(rd_valid), 32'd0);
      chk("async_state", 32'(state), 32'd0);
      chk("async_data", rd_data, 32'd0);
      exp_q.delete();
      @(negedge clk);
      rst = 1'b1;
      cyc();
      chk("post_rst_state", 32'(state), 32'd0);
      chk("post_rst_valid", 32'(rd_valid), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
